// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Also holds the baud-increment helper that the future receiver will use.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned baud_gen_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input int unsigned     acc_w);
    longint unsigned num;
    num = (baud << (acc_w - 4)) + (clk_freq >> 5);
    return int'(num / (clk_freq >> 4));
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud-tick generator: a phase accumulator whose carry-out is the tick.
// The tick is the carry of this cycle's addition, so a cleared accumulator yields a full first period.
module uart_baud_gen #(
  parameter int unsigned AccWidth = 16,
  parameter int unsigned Inc      = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [AccWidth:0] IncW = (AccWidth + 1)'(Inc);

  logic [AccWidth-1:0] acc_q, acc_d;
  logic [AccWidth:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + IncW;
    acc_d  = clr_i ? '0 : sum[AccWidth-1:0];
    tick_o = ~clr_i & sum[AccWidth];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// 8N1 UART transmitter shared round-robin between NUM_REQ byte requesters.
// Arbitration happens in the single IDLE cycle between frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ           = 50000000,
  parameter int unsigned BAUD               = 9600,
  parameter int unsigned BAUD_GEN_ACC_WIDTH = 16,
  parameter int unsigned NUM_REQ            = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned BAUD_GEN_INC = baud_gen_inc(CLK_FREQ, BAUD, BAUD_GEN_ACC_WIDTH);
  localparam int unsigned GidW         = $clog2(NUM_REQ);
  localparam int unsigned DataBits     = FRAME_BITS - 2;

  tx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [GidW-1:0]   grant_id_q, grant_id_d;
  logic              tx_q, tx_d;

  logic              tick;
  logic              baud_clr;
  logic              any_req;
  logic [GidW-1:0]   sel;
  logic [GidW-1:0]   scan_idx;
  logic [7:0]        sel_byte;

  uart_baud_gen #(
    .AccWidth(BAUD_GEN_ACC_WIDTH),
    .Inc     (BAUD_GEN_INC)
  ) u_baud_gen (
    .clk_i (clk),
    .rst_ni(reset_n),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  // Round-robin: scan upward from the requester after the last one served.
  always_comb begin
    any_req  = 1'b0;
    sel      = grant_id_q;
    scan_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx = GidW'((32'(grant_id_q) + i) % NUM_REQ);
      if (!any_req && req_valid[scan_idx]) begin
        any_req = 1'b1;
        sel     = scan_idx;
      end
    end
    sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == GidW'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      grant_id_q <= GidW'(NUM_REQ - 1);
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      grant_id_q <= grant_id_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    grant_id_d = grant_id_q;
    baud_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StStart;
          shift_d    = sel_byte;
          grant_id_d = sel;
          baud_clr   = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DataBits - 1)) state_d = StStop;
        end
      end
      StStop: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from the next state so the line changes with the state.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    req_ready = '0;
    if (state_q == StIdle && any_req) req_ready[sel] = 1'b1;
  end

  assign tx       = tx_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic, checked every cycle
// against a frame-timing model (160-clk frames, 1-clk arbitration gap, round-robin order).
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NumReq   = 4;
  localparam int BitClk   = 16;
  localparam int FrameClk = FRAME_BITS * BitClk;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NumReq-1:0]     req_valid;
  logic [8*NumReq-1:0]   req_data;
  logic [NumReq-1:0]     req_ready;
  logic                  tx;
  logic                  busy;
  logic [1:0]            grant_id;

  logic       valid_r [NumReq];
  logic [7:0] data_r  [NumReq];
  int         cnt     [NumReq];
  logic       ack     [NumReq];

  int n_total = 0;
  int n_bad   = 0;

  int         rem  = 0;
  int         last = NumReq - 1;
  logic [9:0] frame = '1;
  int         served[$];
  int         eq[$];

  for (genvar g = 0; g < NumReq; g++) begin : g_drv
    assign req_valid[g]        = valid_r[g];
    assign req_data[8*g +: 8]  = data_r[g];
  end

  uart_tx_sched #(
    .CLK_FREQ          (1600000),
    .BAUD              (100000),
    .BAUD_GEN_ACC_WIDTH(16),
    .NUM_REQ           (NumReq)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle against the inputs held for that cycle.
  always @(negedge clk) begin : model
    int               sel;
    logic             exp_tx;
    logic [NumReq-1:0] exp_rdy;
    sel     = -1;
    exp_rdy = '0;
    if (!reset_n) begin
      rem  = 0;
      last = NumReq - 1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant", grant_id, NumReq - 1);
    end else begin
      exp_tx = (rem > 0) ? frame[(FrameClk - rem) / BitClk] : 1'b1;
      chk("busy", busy, rem > 0);
      chk("tx", tx, exp_tx);
      chk("grant", grant_id, last);
      if (rem == 0) begin
        for (int k = 1; k <= NumReq; k++) begin
          if (sel < 0 && req_valid[(last + k) % NumReq]) sel = (last + k) % NumReq;
        end
      end
      if (sel >= 0) exp_rdy[sel] = 1'b1;
      chk("ready", req_ready, exp_rdy);
      if (rem > 0) begin
        rem--;
      end else if (sel >= 0) begin
        last  = sel;
        frame = {1'b1, data_r[sel], 1'b0};
        rem   = FrameClk;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      ack[i] = req_ready[i];
      if (req_ready[i] === 1'b1) served.push_back(i);
    end
  end

  // Advance one cycle; requesters react to the accept seen in the previous cycle.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NumReq; i++) begin
      if (ack[i] === 1'b1) begin
        if (cnt[i] > 1) begin
          cnt[i]--;
          data_r[i] = 8'($urandom);
        end else begin
          cnt[i]     = 0;
          valid_r[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input int n);
    data_r[i]  = d;
    cnt[i]     = n;
    valid_r[i] = 1'b1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NumReq; i++) if (cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    step();
    while ((pending() || rem != 0) && b < 4000) begin
      step();
      b++;
    end
    if (b >= 4000) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic chk_served(input string tag);
    chk({tag, "_count"}, served.size(), eq.size());
    foreach (eq[k]) begin
      if (k < served.size()) chk({tag, "_order"}, served[k], eq[k]);
    end
    served.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NumReq; i++) begin
      valid_r[i] = 1'b0;
      data_r[i]  = '0;
      cnt[i]     = 0;
    end
    repeat (3) step();
    #2 reset_n = 1'b1;
    step();
    served.delete();

    // All four held from reset: 0,1,2,3 then 0 again.
    for (int i = 0; i < NumReq; i++) send(i, 8'(8'h41 + i), (i == 0) ? 2 : 1);
    wait_idle("all4");
    eq = '{0, 1, 2, 3, 0};
    chk_served("all4");

    // Single byte 0x61 from requester 0.
    send(0, 8'h61, 1);
    wait_idle("single");
    eq = '{0};
    chk_served("single");
    chk("single_grant", grant_id, 0);

    // Wrap-around: after serving 3, requesters 0 and 2 go 0 then 2.
    send(3, 8'h5A, 1);
    wait_idle("pre_wrap");
    chk("wrap_grant3", grant_id, 3);
    send(0, 8'hC3, 1);
    send(2, 8'h0F, 1);
    wait_idle("wrap");
    eq = '{3, 0, 2};
    chk_served("wrap");

    // Withdrawal during busy is never granted.
    send(0, 8'h96, 1);
    run_steps(40);
    valid_r[1] = 1'b1;
    data_r[1]  = 8'hEE;
    step();
    valid_r[1] = 1'b0;
    wait_idle("withdraw");
    eq = '{0};
    chk_served("withdraw");

    // Reset in the middle of data bit 3 (a zero bit of 0xA5).
    send(2, 8'hA5, 1);
    run_steps(1 + BitClk + 3 * BitClk + 8);
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_grant", grant_id, NumReq - 1);
    repeat (3) step();
    #2 reset_n = 1'b1;
    step();
    served.delete();
    send(1, 8'h3C, 1);
    wait_idle("post_rst");
    eq = '{1};
    chk_served("post_rst");

    // Random traffic with occasional withdrawals.
    served.delete();
    for (int c = 0; c < 15000; c++) begin
      for (int i = 0; i < NumReq; i++) begin
        if (!valid_r[i] && $urandom_range(0, 63) == 0) begin
          send(i, 8'($urandom), int'($urandom_range(1, 3)));
        end else if (valid_r[i] && $urandom_range(0, 399) == 0) begin
          valid_r[i] = 1'b0;
          cnt[i]     = 0;
        end
      end
      step();
    end
    wait_idle("random");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  task automatic run_steps(input int n);
    repeat (n) step();
  endtask

endmodule
